// File: rtl/pipelined_adder_pkg.sv
// Shared types, defaults and sizing helper for the pipelined carry-chunk adder.
// Optional feature macro used across this slice: ADDER_OVF_EN (signed overflow output).
package adder_pkg;

  localparam int ADDER_WIDTH_DEF  = 16;
  localparam int ADDER_STAGES_DEF = 4;

  // Bits summed per pipeline stage; a zero stage count degrades to one full-width stage.
  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  localparam int ADDER_CHUNK_DEF = ADDER_WIDTH_DEF / ADDER_STAGES_DEF;

  typedef struct packed {
    logic                                        valid;
    logic                                        carry;
    logic [ADDER_CHUNK_DEF-1:0]                  sum;
    logic [ADDER_WIDTH_DEF-ADDER_CHUNK_DEF-1:0]  pend_a;
    logic [ADDER_WIDTH_DEF-ADDER_CHUNK_DEF-1:0]  pend_b;
  } adder_stage_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; slave = adder, master = producer/consumer.
// out_ovf is present only when ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = adder_pkg::ADDER_WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef ADDER_OVF_EN
  logic             out_ovf;
`endif

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
`ifdef ADDER_OVF_EN
    , output out_ovf
`endif
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
`ifdef ADDER_OVF_EN
    , input out_ovf
`endif
  );

endinterface

// File: rtl/pipelined_adder_add_stage.sv
// One CHUNK-bit slice of the pipelined adder: ripple add of the chunk plus carry-in,
// with registered sum and carry-out that only move when the pipeline advances.
module add_stage #(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic [CHUNK-1:0] sum_q;
  logic [CHUNK-1:0] sum_d;
  logic             cout_q;
  logic             cout_d;

  always_comb begin
    {cout_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (en_i) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES chunk stages with a single global advance (valid/ready).
// Define ADDER_OVF_EN to add the registered signed-overflow output out_ovf.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH_DEF,
  parameter int STAGES = ADDER_STAGES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  pipelined_adder_if.slave    bus
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $fatal(1, "pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic              adv;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  // Whole pipe moves together; a full output register blocks everything behind it.
  assign adv         = ~valid_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;

  if (STAGES == 1) begin : g_valid_one
    assign valid_d = bus.in_valid;
  end else begin : g_valid_many
    assign valid_d = {valid_q[STAGES-2:0], bus.in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * CHUNK;
    localparam int HI = LO + CHUNK;

    // rem_*: operand bits not yet summed, lowest chunk belongs to this stage.
    logic [WIDTH-LO-1:0] rem_a;
    logic [WIDTH-LO-1:0] rem_b;
    logic                carry_in;
    logic [CHUNK-1:0]    chunk_sum;
    logic                chunk_cout;
    logic [HI-1:0]       full_sum;

    if (gi == 0) begin : g_src
      assign rem_a    = bus.in_a;
      assign rem_b    = bus.in_b;
      assign carry_in = bus.in_cin;
    end else begin : g_src
      assign rem_a    = g_stage[gi-1].g_pend.opa_q;
      assign rem_b    = g_stage[gi-1].g_pend.opb_q;
      assign carry_in = g_stage[gi-1].chunk_cout;
    end

    add_stage #(
      .CHUNK (CHUNK)
    ) u_add (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (adv),
      .a_i    (rem_a[CHUNK-1:0]),
      .b_i    (rem_b[CHUNK-1:0]),
      .c_i    (carry_in),
      .sum_o  (chunk_sum),
      .cout_o (chunk_cout)
    );

    if (gi == 0) begin : g_low
      assign full_sum = chunk_sum;
    end else begin : g_low
      // Deskew: already-finished low sum bits travel alongside the op.
      logic [LO-1:0] low_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          low_q <= '0;
        end else if (adv) begin
          low_q <= g_stage[gi-1].full_sum;
        end
      end
      assign full_sum = {chunk_sum, low_q};
    end

    if (HI < WIDTH) begin : g_pend
      logic [WIDTH-HI-1:0] opa_q;
      logic [WIDTH-HI-1:0] opb_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (adv) begin
          opa_q <= rem_a[WIDTH-LO-1:CHUNK];
          opb_q <= rem_b[WIDTH-LO-1:CHUNK];
        end
      end
    end
  end

  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  assign sum_out       = g_stage[STAGES-1].full_sum;
  assign cout_out      = g_stage[STAGES-1].chunk_cout;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_sum   = sum_out;
  assign bus.out_cout  = cout_out;

`ifdef ADDER_OVF_EN
  // Carry into the MSB is a^b^sum at that bit; keep a^b registered beside the sum.
  logic msb_axb_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_axb_q <= 1'b0;
    end else if (adv) begin
      msb_axb_q <= g_stage[STAGES-1].rem_a[CHUNK-1] ^ g_stage[STAGES-1].rem_b[CHUNK-1];
    end
  end
  assign bus.out_ovf = msb_axb_q ^ sum_out[WIDTH-1] ^ cout_out;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4) with a result scoreboard.
// Overflow checks are compiled in when ADDER_OVF_EN is defined.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_out  = 0;
  bit   check_lat = 1'b1;
  exp_t sb[$];

  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int acc);
    exp_t        e;
    logic [W:0]  full;
    full      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum     = full[W-1:0];
    e.cout    = full[W];
    e.ovf     = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e.acc_cyc = acc;
    return e;
  endfunction

  // Scoreboard: pop on every output transfer, push on every input transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(bus.out_sum), 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_sum", 32'(bus.out_sum), 32'(e.sum));
          check("out_cout", 32'(bus.out_cout), 32'(e.cout));
`ifdef ADDER_OVF_EN
          check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
          last_ovf = bus.out_ovf;
`endif
          if (check_lat) check("latency", 32'(cyc - e.acc_cyc), 32'(S));
          last_sum  = bus.out_sum;
          last_cout = bus.out_cout;
          n_out++;
          $display("[%0t] out sum=0x%04h cout=%0b", $time, bus.out_sum, bus.out_cout);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_a, bus.in_b, bus.in_cin, cyc));
        $display("[%0t] in  a=0x%04h b=0x%04h cin=%0b", $time, bus.in_a, bus.in_b, bus.in_cin);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int waited;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = c;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) check("send_timeout", 32'(waited), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      waited++;
      @(posedge clk);
    end
    if (waited >= 200) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           n_before;
    int           waited;
    logic [W-1:0] held_sum;
    logic         held_cout;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h1234;
    bus.in_b      = 16'h4321;
    bus.in_cin    = 1'b1;
    bus.out_ready = 1'b1;

    // 1: reset held with in_valid asserted
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_sum", 32'(bus.out_sum), 32'd0);
      check("rst_out_cout", 32'(bus.out_cout), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;

    // 2: carry across a chunk boundary
    send(16'h00FF, 16'h0001, 1'b0);
    drain();
    check("t2_sum", 32'(last_sum), 32'h0100);
    check("t2_cout", 32'(last_cout), 32'd0);

    // 3: carry-in ripples through every stage
    send(16'hFFFF, 16'h0000, 1'b1);
    drain();
    check("t3_sum", 32'(last_sum), 32'h0000);
    check("t3_cout", 32'(last_cout), 32'd1);
`ifdef ADDER_OVF_EN
    check("t3_ovf", 32'(last_ovf), 32'd0);
`endif

    // 4: back-to-back stream
    n_before = n_out;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = W'($urandom_range(0, 65535));
      bus.in_b     = W'($urandom_range(0, 65535));
      bus.in_cin   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("t4_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    check("t4_count", 32'(n_out - n_before), 32'd8);

    // 5: backpressure
    check_lat = 1'b0;
    n_before  = n_out;
    for (int i = 0; i < 4; i++) send(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), 1'b0);
    waited = 0;
    @(negedge clk);
    while (!bus.out_valid && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 20) check("t5_wait_valid", 32'(waited), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    held_sum  = bus.out_sum;
    held_cout = bus.out_cout;
    repeat (3) begin
      @(negedge clk);
      check("t5_in_ready", 32'(bus.in_ready), 32'd0);
      check("t5_out_valid", 32'(bus.out_valid), 32'd1);
      check("t5_held_sum", 32'(bus.out_sum), 32'(held_sum));
      check("t5_held_cout", 32'(bus.out_cout), 32'(held_cout));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    check("t5_count", 32'(n_out - n_before), 32'd4);
    check_lat = 1'b1;

    // 6: signed overflow, then reset with ops in flight
    send(16'h7FFF, 16'h0001, 1'b0);
    drain();
    check("t6_sum", 32'(last_sum), 32'h8000);
`ifdef ADDER_OVF_EN
    check("t6_ovf", 32'(last_ovf), 32'd1);
`endif
    n_before = n_out;
    send(16'h0011, 16'h0022, 1'b0);
    send(16'h0033, 16'h0044, 1'b1);
    send(16'h0055, 16'h0066, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t6_no_ghost_valid", 32'(bus.out_valid), 32'd0);
    end
    check("t6_no_ghost_count", 32'(n_out - n_before), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
